// File: rtl/vga_grid_capture.sv
`default_nettype none
// ============================================================================
// vga_grid_capture: rebuilds the ROWS x COLS cell matrix from a VGA stream.
// Optional cursor capture is built when CAPTURE_CURSOR_EN is defined. Rev 1.0
// ============================================================================
module vga_grid_capture #(
  parameter int ROWS        = 30,
  parameter int COLS        = 40,
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 526,
  parameter int GRID_X0     = 164,
  parameter int GRID_Y0     = 55,
  parameter int CELL_W      = 14,
  parameter int CELL_H      = 14,
  parameter int THRESH      = 8,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  input  logic [3:0]           blue_in,
  input  logic [3:0]           green_in,
  input  logic                 capture_en,
  output logic [ROWS*COLS-1:0] grid_out,
  output logic                 frame_done,
  output logic                 locked,
  output logic                 sync_err,
  output logic [7:0]           frame_count,
  output logic [4:0]           cursor_row,
  output logic [5:0]           cursor_col,
  output logic                 cursor_valid
);

  localparam int C_GW = $clog2(LOCK_FRAMES + 1);
  localparam logic [9:0]      c_h_last  = 10'(H_TOTAL - 1);
  localparam logic [9:0]      c_h_total = 10'(H_TOTAL);
  localparam logic [9:0]      c_v_last  = 10'(V_TOTAL - 1);
  localparam logic [9:0]      c_x_start = 10'(GRID_X0 + 1);
  localparam logic [9:0]      c_y_start = 10'(GRID_Y0 + 1);
  localparam logic [9:0]      c_w_last  = 10'(CELL_W - 1);
  localparam logic [9:0]      c_w_mid   = 10'(CELL_W / 2);
  localparam logic [9:0]      c_ch_last = 10'(CELL_H - 1);
  localparam logic [9:0]      c_ch_mid  = 10'(CELL_H / 2);
  localparam logic [4:0]      c_row_last = 5'(ROWS - 1);
  localparam logic [5:0]      c_col_last = 6'(COLS - 1);
  localparam logic [3:0]      c_thresh  = 4'(THRESH);
  localparam logic [C_GW-1:0] c_lock    = C_GW'(LOCK_FRAMES);

  typedef enum logic [0:0] {HUNT = 1'b0, TRACK = 1'b1} state_t;

  logic hs_q, hs_prev_q, vs_q, vs_prev_q, cap_q;
  logic [3:0] blue_q;
  logic hs_rise, vs_rise, sample, err;

  state_t state_q, state_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic [9:0] hph_q, hph_d, vph_q, vph_d;
  logic [5:0] col_q, col_d;
  logic [4:0] row_q, row_d;
  logic hact_q, hact_d, vact_q, vact_d;
  logic [C_GW-1:0] good_q, good_d;
  logic locked_q, locked_d, sync_err_q, sync_err_d, frame_done_q, frame_done_d;
  logic [7:0] count_q, count_d;
  logic [ROWS-1:0][COLS-1:0] shadow_q, shadow_d;
  logic [ROWS*COLS-1:0] grid_q, grid_d;

`ifdef CAPTURE_CURSOR_EN
  logic [3:0] green_q;
  logic [4:0] sh_row_q, sh_row_d, cur_row_q, cur_row_d;
  logic [5:0] sh_col_q, sh_col_d, cur_col_q, cur_col_d;
  logic       sh_vld_q, sh_vld_d, cur_vld_q, cur_vld_d;
`else
  logic unused_green;
  assign unused_green = ^green_in;
`endif

  always_comb begin
    hs_rise = hs_q & ~hs_prev_q;
    vs_rise = vs_q & ~vs_prev_q;
    x_d = hs_rise ? 10'd0 : x_q + 10'd1;
    y_d = y_q;
    if (hs_rise) y_d = vs_rise ? 10'd0 : y_q + 10'd1;

    // Horizontal cell phase: restarts at the grid left edge on every line.
    hph_d = hph_q; col_d = col_q; hact_d = hact_q;
    if (x_d == c_x_start) begin
      hph_d = '0; col_d = '0; hact_d = 1'b1;
    end else if (hs_rise) begin
      hact_d = 1'b0;
    end else if (hact_q) begin
      if (hph_q == c_w_last) begin
        hph_d = '0;
        if (col_q == c_col_last) hact_d = 1'b0;
        else col_d = col_q + 6'd1;
      end else begin
        hph_d = hph_q + 10'd1;
      end
    end

    vph_d = vph_q; row_d = row_q; vact_d = vact_q;
    if (hs_rise) begin
      if (y_d == c_y_start) begin
        vph_d = '0; row_d = '0; vact_d = 1'b1;
      end else if (vact_q) begin
        if (vph_q == c_ch_last) begin
          vph_d = '0;
          if (row_q == c_row_last) vact_d = 1'b0;
          else row_d = row_q + 5'd1;
        end else begin
          vph_d = vph_q + 10'd1;
        end
      end
    end

    sample = hact_d & vact_d & (hph_d == c_w_mid) & (vph_d == c_ch_mid);
    err = (hs_rise && (x_q != c_h_last)) || (!hs_rise && (x_d == c_h_total)) ||
          (vs_rise && (y_q != c_v_last));

    state_d = state_q; good_d = good_q; locked_d = locked_q;
    sync_err_d = 1'b0; frame_done_d = 1'b0;
    count_d = count_q; grid_d = grid_q; shadow_d = shadow_q;
    if (sample) shadow_d[row_d][col_d] = (blue_q >= c_thresh);
`ifdef CAPTURE_CURSOR_EN
    sh_row_d = sh_row_q; sh_col_d = sh_col_q; sh_vld_d = sh_vld_q;
    cur_row_d = cur_row_q; cur_col_d = cur_col_q; cur_vld_d = cur_vld_q;
    if (sample && (green_q >= c_thresh)) begin
      sh_row_d = row_d; sh_col_d = col_d; sh_vld_d = 1'b1;
    end
`endif

    case (state_q)
      HUNT: begin
        if (vs_rise) begin
          state_d = TRACK;
`ifdef CAPTURE_CURSOR_EN
          sh_vld_d = 1'b0;
`endif
        end
      end
      default: begin
        if (err) begin
          state_d = HUNT; sync_err_d = 1'b1; locked_d = 1'b0;
          good_d = '0; shadow_d = '0;
`ifdef CAPTURE_CURSOR_EN
          sh_vld_d = 1'b0;
`endif
        end else if (vs_rise) begin
          good_d = (good_q == c_lock) ? good_q : good_q + 1'b1;
          locked_d = (good_d == c_lock);
          if (cap_q) begin
            grid_d = shadow_q; frame_done_d = 1'b1; count_d = count_q + 8'd1;
`ifdef CAPTURE_CURSOR_EN
            cur_row_d = sh_row_q; cur_col_d = sh_col_q; cur_vld_d = sh_vld_q;
`endif
          end
`ifdef CAPTURE_CURSOR_EN
          sh_vld_d = 1'b0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_q <= 1'b0; hs_prev_q <= 1'b0; vs_q <= 1'b0; vs_prev_q <= 1'b0;
      cap_q <= 1'b0; blue_q <= '0;
      state_q <= HUNT; x_q <= '0; y_q <= '0;
      hph_q <= '0; vph_q <= '0; col_q <= '0; row_q <= '0;
      hact_q <= 1'b0; vact_q <= 1'b0; good_q <= '0;
      locked_q <= 1'b0; sync_err_q <= 1'b0; frame_done_q <= 1'b0;
      count_q <= '0; shadow_q <= '0; grid_q <= '0;
`ifdef CAPTURE_CURSOR_EN
      green_q <= '0; sh_row_q <= '0; sh_col_q <= '0; sh_vld_q <= 1'b0;
      cur_row_q <= '0; cur_col_q <= '0; cur_vld_q <= 1'b0;
`endif
    end else begin
      hs_q <= hsync_in; hs_prev_q <= hs_q; vs_q <= vsync_in; vs_prev_q <= vs_q;
      cap_q <= capture_en; blue_q <= blue_in;
      state_q <= state_d; x_q <= x_d; y_q <= y_d;
      hph_q <= hph_d; vph_q <= vph_d; col_q <= col_d; row_q <= row_d;
      hact_q <= hact_d; vact_q <= vact_d; good_q <= good_d;
      locked_q <= locked_d; sync_err_q <= sync_err_d; frame_done_q <= frame_done_d;
      count_q <= count_d; shadow_q <= shadow_d; grid_q <= grid_d;
`ifdef CAPTURE_CURSOR_EN
      green_q <= green_in; sh_row_q <= sh_row_d; sh_col_q <= sh_col_d; sh_vld_q <= sh_vld_d;
      cur_row_q <= cur_row_d; cur_col_q <= cur_col_d; cur_vld_q <= cur_vld_d;
`endif
    end
  end

  assign grid_out    = grid_q;
  assign frame_done  = frame_done_q;
  assign locked      = locked_q;
  assign sync_err    = sync_err_q;
  assign frame_count = count_q;
`ifdef CAPTURE_CURSOR_EN
  assign cursor_row   = cur_row_q;
  assign cursor_col   = cur_col_q;
  assign cursor_valid = cur_vld_q;
`else
  assign cursor_row   = '0;
  assign cursor_col   = '0;
  assign cursor_valid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_grid_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_vga_grid_capture: directed generator-model bench with a reduced raster.
// Rev 1.0
// ============================================================================
module tb_vga_grid_capture;
  localparam int ROWS = 30, COLS = 40, H_TOTAL = 100, V_TOTAL = 40;
  localparam int GRID_X0 = 10, GRID_Y0 = 4, CELL_W = 2, CELL_H = 1;
  localparam int HS_W = 8;

  logic clk = 1'b0, reset = 1'b1;
  logic hsync_in = 1'b0, vsync_in = 1'b0, capture_en = 1'b0;
  logic [3:0] blue_in = '0, green_in = '0;
  logic [ROWS*COLS-1:0] grid_out;
  logic frame_done, locked, sync_err, cursor_valid;
  logic [7:0] frame_count;
  logic [4:0] cursor_row;
  logic [5:0] cursor_col;

  vga_grid_capture #(
    .ROWS(ROWS), .COLS(COLS), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
    .GRID_X0(GRID_X0), .GRID_Y0(GRID_Y0), .CELL_W(CELL_W), .CELL_H(CELL_H),
    .THRESH(8), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .blue_in(blue_in), .green_in(green_in), .capture_en(capture_en),
    .grid_out(grid_out), .frame_done(frame_done), .locked(locked),
    .sync_err(sync_err), .frame_count(frame_count), .cursor_row(cursor_row),
    .cursor_col(cursor_col), .cursor_valid(cursor_valid)
  );

  always #20 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic [3:0] blue_cell  [ROWS][COLS];
  logic [3:0] green_cell [ROWS][COLS];

  int fd_pulses, fd_high, fd_pos, se_pulses, se_high;
  logic fd_prev = 1'b0, se_prev = 1'b0;
  logic snap_locked, end_locked, snap_cur_valid;
  logic [7:0] snap_count, end_count;
  logic [4:0] snap_cur_row;
  logic [5:0] snap_cur_col;
  logic [ROWS*COLS-1:0] snap_grid;

  // One video frame; bad_line (if in range) is one clock short.
  task automatic gen_frame(input int bad_line);
    int len, pos, r, c;
    fd_pulses = 0; fd_high = 0; fd_pos = -1; se_pulses = 0; se_high = 0;
    pos = 0;
    for (int y = 0; y < V_TOTAL; y++) begin
      len = (y == bad_line) ? H_TOTAL - 1 : H_TOTAL;
      for (int x = 0; x < len; x++) begin
        @(negedge clk);
        if (frame_done) fd_high++;
        if (frame_done && !fd_prev) begin fd_pulses++; fd_pos = pos; end
        fd_prev = frame_done;
        if (sync_err) se_high++;
        if (sync_err && !se_prev) se_pulses++;
        se_prev = sync_err;
        if (pos == 5) begin
          snap_locked = locked; snap_count = frame_count; snap_grid = grid_out;
          snap_cur_row = cursor_row; snap_cur_col = cursor_col; snap_cur_valid = cursor_valid;
        end
        end_locked = locked; end_count = frame_count;
        hsync_in = (x < HS_W);
        vsync_in = (y < 2);
        blue_in = 4'd0; green_in = 4'd0;
        if (x >= GRID_X0 + 1 && x < GRID_X0 + 1 + COLS * CELL_W &&
            y >= GRID_Y0 + 1 && y < GRID_Y0 + 1 + ROWS * CELL_H) begin
          c = (x - GRID_X0 - 1) / CELL_W;
          r = (y - GRID_Y0 - 1) / CELL_H;
          blue_in = blue_cell[r][c];
          green_in = green_cell[r][c];
        end
        pos++;
      end
    end
  endtask

  initial begin
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        blue_cell[r][c] = 4'd0; green_cell[r][c] = 4'd0;
      end
    blue_cell[0][1] = 4'd9; blue_cell[1][2] = 4'd9; blue_cell[2][0] = 4'd9;
    blue_cell[2][1] = 4'd9; blue_cell[2][2] = 4'd9;
    blue_cell[5][5] = 4'd7; blue_cell[5][6] = 4'd8;
    green_cell[7][12] = 4'd9;

    // Reset held with toggling inputs.
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      hsync_in = 1'($urandom_range(0, 1)); vsync_in = 1'($urandom_range(0, 1));
      blue_in = 4'($urandom_range(0, 15)); green_in = 4'($urandom_range(0, 15));
      capture_en = 1'($urandom_range(0, 1));
      if (i % 10 == 9) begin
        check("rst_grid", 64'($countones(grid_out)), 0);
        check("rst_locked", locked, 0);
        check("rst_done", frame_done, 0);
        check("rst_count", frame_count, 0);
        check("rst_err", sync_err, 0);
      end
    end
    @(negedge clk);
    hsync_in = 0; vsync_in = 0; blue_in = 0; green_in = 0; capture_en = 1;
    reset = 0;

    gen_frame(-1);  // F0: HUNT -> TRACK, nothing published
    check("f0_done", fd_pulses, 0);
    check("f0_count", end_count, 0);
    check("f0_locked", end_locked, 0);

    gen_frame(-1);  // F1: first full tracked frame closes
    check("f1_done", fd_pulses, 1);
    check("f1_done_width", fd_high, 1);
    check("f1_done_pos", fd_pos, 2);
    check("f1_count", snap_count, 1);
    check("f1_locked", snap_locked, 0);
    check("f1_bit1", snap_grid[1], 1);
    check("f1_bit42", snap_grid[42], 1);
    check("f1_bit80", snap_grid[80], 1);
    check("f1_bit81", snap_grid[81], 1);
    check("f1_bit82", snap_grid[82], 1);
    check("f1_bit205", snap_grid[205], 0);
    check("f1_bit206", snap_grid[206], 1);
    check("f1_ones", 64'($countones(snap_grid)), 6);
    check("f1_err", se_pulses, 0);
`ifdef CAPTURE_CURSOR_EN
    check("cur_row", snap_cur_row, 7);
    check("cur_col", snap_cur_col, 12);
    check("cur_valid", snap_cur_valid, 1);
`else
    check("cur_row", snap_cur_row, 0);
    check("cur_col", snap_cur_col, 0);
    check("cur_valid", snap_cur_valid, 0);
`endif

    gen_frame(-1);  // F2: second close locks
    check("f2_locked", snap_locked, 1);
    check("f2_count", snap_count, 2);
    check("f2_done", fd_pulses, 1);

    gen_frame(20);  // F3: one short line
    check("f3_done", fd_pulses, 1);
    check("f3_count", snap_count, 3);
    check("f3_err", se_pulses, 1);
    check("f3_err_width", se_high, 1);
    check("f3_locked_end", end_locked, 0);

    gen_frame(-1);  // F4: re-enter TRACK, no publish
    check("f4_done", fd_pulses, 0);
    check("f4_err", se_pulses, 0);
    check("f4_count", end_count, 3);
    check("f4_ones", 64'($countones(snap_grid)), 6);

    gen_frame(-1);  // F5
    check("f5_done", fd_pulses, 1);
    check("f5_done_pos", fd_pos, 2);
    check("f5_count", snap_count, 4);
    check("f5_locked", snap_locked, 0);

    gen_frame(-1);  // F6
    check("f6_locked", snap_locked, 1);
    check("f6_count", snap_count, 5);

    capture_en = 0;
    blue_cell[10][10] = 4'd15;
    gen_frame(10);  // F7: disabled close, then an error
    check("f7_done", fd_pulses, 0);
    check("f7_err", se_pulses, 1);
    check("f7_locked_end", end_locked, 0);
    gen_frame(-1);  // F8
    check("f8_done", fd_pulses, 0);
    gen_frame(-1);  // F9
    check("f9_done", fd_pulses, 0);
    check("f9_locked", snap_locked, 0);
    gen_frame(-1);  // F10
    check("f10_done", fd_pulses, 0);
    check("f10_locked", snap_locked, 1);
    check("f10_count", snap_count, 5);
    check("f10_bit410", snap_grid[410], 0);
    check("f10_ones", 64'($countones(snap_grid)), 6);

    capture_en = 1;
    gen_frame(-1);  // F11: publishing resumes
    check("f11_done", fd_pulses, 1);
    check("f11_count", snap_count, 6);
    check("f11_bit410", snap_grid[410], 1);
    check("f11_ones", 64'($countones(snap_grid)), 7);
    check("f11_locked", snap_locked, 1);

    // Mid-frame reset clears everything immediately.
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    check("mid_rst_locked", locked, 0);
    check("mid_rst_count", frame_count, 0);
    check("mid_rst_grid", 64'($countones(grid_out)), 0);
    reset = 0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
